alu_exec_sequencer: RTL and testbench

Single-issue controller that sequences alu_stage for one instruction at a time. It accepts a 32-bit RV32I instruction over a valid/ready handshake, decodes it, drives regfile read addresses and ALU controls, and waits for result_ready. It then writes the result back to the regfile and returns to idle. It also flags illegal instructions, detects an ALU that never responds, and counts retired instructions.

---
 rtl/alu_exec_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_sequencer (plus package alu_enums_pkg)
//  Description : Single-issue controller that steps alu_stage through one
//                RV32I instruction at a time. An instruction is accepted over
//                a valid/ready handshake and decoded. Legal instructions
//                (ADDI only) then pass through ISSUE -> WAIT -> WRITEBACK.
//                Illegal ones raise a one-cycle trap. An ALU that never
//                answers parks the block in a sticky ERROR state.
//
//  Ports       : clk, reset_n                 clock / async active-low reset
//                instr_valid/_data/_ready     instruction handshake
//                rf_rd0_addr, rf_rd1_addr     regfile read addresses
//                alu_immediate,
//                alu_input_a_is_immediate,
//                alu_op                       controls to alu_stage
//                alu_result_ready, alu_result response from alu_stage
//                rf_wr_en/_addr/_data         regfile write port
//                illegal_instr                one-cycle trap pulse
//                timeout_error                sticky ALU-timeout flag
//                busy                         high in every state but IDLE
//                retired_count                retired-instruction counter
//
//  Revision    : 1.0  initial release
// ============================================================================

package alu_enums_pkg;
    // ALU command encoding shared with alu_stage. ALU_NONE is the all-zero
    // code, so a reset or idle controller presents an inert command.
    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_command_t;
endpackage

module alu_exec_sequencer
    import alu_enums_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4,   // 1..255
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr_data,
    output logic             instr_ready,
    output logic [4:0]       rf_rd0_addr,
    output logic [4:0]       rf_rd1_addr,
    output logic [11:0]      alu_immediate,
    output logic             alu_input_a_is_immediate,
    output alu_command_t     alu_op,
    input  logic             alu_result_ready,
    input  logic [31:0]      alu_result,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_addr,
    output logic [31:0]      rf_wr_data,
    output logic             illegal_instr,
    output logic             timeout_error,
    output logic             busy,
    output logic [CNT_W-1:0] retired_count
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_DECODE    = 3'd1;
    localparam logic [2:0] c_ST_ISSUE     = 3'd2;
    localparam logic [2:0] c_ST_WAIT      = 3'd3;
    localparam logic [2:0] c_ST_WRITEBACK = 3'd4;
    localparam logic [2:0] c_ST_TRAP      = 3'd5;
    localparam logic [2:0] c_ST_ERROR     = 3'd6;

    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [2:0] c_F3_ADDI      = 3'b000;

    // The WAIT counter holds the number of WAIT cycles already completed.
    // The cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    localparam logic [7:0]       c_TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       c_TMO_ONE   = 8'd1;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [31:0]      r_instr;     // instruction latched at accept
    logic [31:0]      r_result;    // ALU result captured in WAIT
    logic [7:0]       r_tmo_cnt;
    logic [CNT_W-1:0] r_retired;
    // Holds instr_ready low while reset is asserted. instr_ready can
    // therefore read 0 along with every other output during reset, even
    // though the state register already reads IDLE.
    logic             r_live;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [2:0]  w_next_state;
    logic        w_accept;
    logic        w_legal;
    logic        w_tmo_hit;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [11:0] w_imm;

    // Field extraction is always taken from the latched word. Changes on
    // instr_data while busy therefore have no effect.
    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_imm    = r_instr[31:20];

    assign w_legal   = (w_opcode == c_OPC_OP_IMM) && (w_funct3 == c_F3_ADDI);
    assign w_accept  = instr_valid && r_live && (r_state == c_ST_IDLE);
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                w_next_state = w_legal ? c_ST_ISSUE : c_ST_TRAP;
            end
            c_ST_ISSUE: begin
                w_next_state = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A response in the final allowed cycle still wins over
                // the timeout.
                if (alu_result_ready) begin
                    w_next_state = c_ST_WRITEBACK;
                end else if (w_tmo_hit) begin
                    w_next_state = c_ST_ERROR;
                end
            end
            c_ST_WRITEBACK: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_TRAP: begin
                w_next_state = c_ST_IDLE;
            end
            c_ST_ERROR: begin
                w_next_state = c_ST_ERROR;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state and latched fields)
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready              = 1'b0;
        rf_rd0_addr              = 5'd0;
        rf_rd1_addr              = 5'd0;
        alu_immediate            = 12'd0;
        alu_input_a_is_immediate = 1'b0;
        alu_op                   = ALU_NONE;
        rf_wr_en                 = 1'b0;
        rf_wr_addr               = 5'd0;
        rf_wr_data               = 32'd0;
        illegal_instr            = 1'b0;
        timeout_error            = 1'b0;
        busy                     = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                instr_ready = r_live;
            end
            c_ST_DECODE: begin
                rf_rd1_addr = w_rs1;
            end
            c_ST_ISSUE: begin
                rf_rd1_addr              = w_rs1;
                alu_immediate            = w_imm;
                alu_input_a_is_immediate = 1'b1;
                alu_op                   = ALU_ADD;
            end
            c_ST_WAIT: begin
                // Keep the read address stable while alu_stage works.
                rf_rd1_addr = w_rs1;
            end
            c_ST_WRITEBACK: begin
                // x0 is hardwired to zero, so writes to it are dropped.
                rf_wr_en   = (w_rd != 5'd0);
                rf_wr_addr = w_rd;
                rf_wr_data = r_result;
            end
            c_ST_TRAP: begin
                illegal_instr = 1'b1;
            end
            c_ST_ERROR: begin
                timeout_error = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign retired_count = r_retired;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live    <= 1'b0;
            r_instr   <= 32'd0;
            r_result  <= 32'd0;
            r_tmo_cnt <= 8'd0;
            r_retired <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_instr <= instr_data;
            end
            case (r_state)
                c_ST_ISSUE: begin
                    r_tmo_cnt <= 8'd0;
                end
                c_ST_WAIT: begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                    if (alu_result_ready) begin
                        r_result <= alu_result;
                    end
                end
                c_ST_WRITEBACK: begin
                    r_retired <= r_retired + c_CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_sequencer
//  Description : Self-checking bench for alu_exec_sequencer. The bench plays
//                the regfile and the ALU. A reference regfile and a retired
//                counter predict every observable result from the
//                instruction fields alone.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_sequencer;
    import alu_enums_pkg::*;

    localparam int TMO = 4;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr_data = 32'd0;
    logic          instr_ready;
    logic [4:0]    rf_rd0_addr, rf_rd1_addr;
    logic [11:0]   alu_immediate;
    logic          alu_input_a_is_immediate;
    alu_command_t  alu_op;
    logic          alu_result_ready = 1'b0;
    logic [31:0]   alu_result = 32'd0;
    logic          rf_wr_en;
    logic [4:0]    rf_wr_addr;
    logic [31:0]   rf_wr_data;
    logic          illegal_instr, timeout_error, busy;
    logic [CW-1:0] retired_count;

    alu_exec_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .instr_valid              (instr_valid),
        .instr_data               (instr_data),
        .instr_ready              (instr_ready),
        .rf_rd0_addr              (rf_rd0_addr),
        .rf_rd1_addr              (rf_rd1_addr),
        .alu_immediate            (alu_immediate),
        .alu_input_a_is_immediate (alu_input_a_is_immediate),
        .alu_op                   (alu_op),
        .alu_result_ready         (alu_result_ready),
        .alu_result               (alu_result),
        .rf_wr_en                 (rf_wr_en),
        .rf_wr_addr               (rf_wr_addr),
        .rf_wr_data               (rf_wr_data),
        .illegal_instr            (illegal_instr),
        .timeout_error            (timeout_error),
        .busy                     (busy),
        .retired_count            (retired_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_seen = 0;
    int wr_exp  = 0;
    int last_accept = 0;
    bit spacing_armed = 1'b0;

    logic [31:0]   rf_hw  [32];   // regfile as written by the DUT
    logic [31:0]   rf_ref [32];   // reference architectural state
    logic [CW-1:0] exp_retired;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rf_wr_en === 1'b1) wr_seen <= wr_seen + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   instr_ready, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_wr_en"},   rf_wr_en, 0);
        check({tag, "_wr_addr"}, rf_wr_addr, 0);
        check({tag, "_wr_data"}, rf_wr_data, 0);
        check({tag, "_rd0"},     rf_rd0_addr, 0);
        check({tag, "_rd1"},     rf_rd1_addr, 0);
        check({tag, "_imm"},     alu_immediate, 0);
        check({tag, "_a_imm"},   alu_input_a_is_immediate, 0);
        check({tag, "_op"},      alu_op, ALU_NONE);
        check({tag, "_illegal"}, illegal_instr, 0);
        check({tag, "_tmo"},     timeout_error, 0);
        check({tag, "_retired"}, retired_count, 0);
    endtask

    // Reset is asserted asynchronously, mid-cycle.
    task automatic do_reset();
        instr_valid      = 1'b0;
        alu_result_ready = 1'b0;
        reset_n          = 1'b0;
        #1;
        check_all_zero("rst_now");
        tick();
        tick();
        check_all_zero("rst_held");
        reset_n = 1'b1;
        tick();
        check("rst_release_ready", instr_ready, 1);
        exp_retired = '0;
    endtask

    // Run one instruction from an IDLE cycle back to IDLE. delay is the
    // number of WAIT cycles with result_ready low. delay >= TMO means the
    // ALU never answers. hold keeps instr_valid high while busy.
    task automatic do_instr(input logic [31:0] instr, input int delay, input bit hold);
        logic [4:0]  rd, rs1;
        logic [11:0] imm;
        logic [31:0] exp_val, alu_res;
        bit          legal;
        rd    = instr[11:7];
        rs1   = instr[19:15];
        imm   = instr[31:20];
        legal = (instr[6:0] == 7'b0010011) && (instr[14:12] == 3'b000);
        exp_val = rf_ref[rs1] + 32'($signed(imm));

        check("idle_ready", instr_ready, 1);
        instr_valid = 1'b1;
        instr_data  = instr;
        tick();
        if (spacing_armed) check("accept_spacing", 64'(cyc - last_accept), 5);
        last_accept = cyc;
        instr_valid = hold;
        instr_data  = $urandom;
        // DECODE
        check("dec_busy",  busy, 1);
        check("dec_ready", instr_ready, 0);
        check("dec_rd1",   rf_rd1_addr, rs1);
        check("dec_rd0",   rf_rd0_addr, 0);
        check("dec_op",    alu_op, ALU_NONE);
        tick();
        if (!legal) begin
            check("trap_pulse", illegal_instr, 1);
            check("trap_op",    alu_op, ALU_NONE);
            check("trap_wr",    rf_wr_en, 0);
            tick();
            check("trap_end_pulse", illegal_instr, 0);
            check("trap_end_ready", instr_ready, 1);
            check("trap_retired",   retired_count, exp_retired);
            return;
        end
        // ISSUE
        check("iss_op",    alu_op, ALU_ADD);
        check("iss_a_imm", alu_input_a_is_immediate, 1);
        check("iss_imm",   alu_immediate, imm);
        check("iss_rd1",   rf_rd1_addr, rs1);
        alu_res = rf_hw[rf_rd1_addr] + {{20{alu_immediate[11]}}, alu_immediate};
        tick();
        // WAIT
        for (int k = 0; k < delay && k < TMO; k++) begin
            check("wait_op",  alu_op, ALU_NONE);
            check("wait_wr",  rf_wr_en, 0);
            check("wait_tmo", timeout_error, 0);
            tick();
        end
        if (delay >= TMO) begin
            check("tmo_flag",  timeout_error, 1);
            check("tmo_ready", instr_ready, 0);
            check("tmo_busy",  busy, 1);
            check("tmo_op",    alu_op, ALU_NONE);
            return;
        end
        alu_result_ready = 1'b1;
        alu_result       = alu_res;
        tick();
        alu_result_ready = 1'b0;
        alu_result       = $urandom;
        // WRITEBACK
        check("wb_en", rf_wr_en, (rd != 5'd0));
        if (rd != 5'd0) begin
            check("wb_addr", rf_wr_addr, rd);
            check("wb_data", rf_wr_data, exp_val);
            rf_ref[rd] = exp_val;
            wr_exp++;
        end
        if (rf_wr_en === 1'b1) rf_hw[rf_wr_addr] = rf_wr_data;
        exp_retired = exp_retired + 1'b1;
        tick();
        // IDLE
        check("end_ready",   instr_ready, 1);
        check("end_wr",      rf_wr_en, 0);
        check("end_busy",    busy, 0);
        check("end_retired", retired_count, exp_retired);
    endtask

    initial begin
        logic [31:0] w;
        rf_hw[0]  = 32'd0;
        rf_ref[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            rf_hw[i]  = $urandom;
            rf_ref[i] = rf_hw[i];
        end
        exp_retired = '0;

        do_reset();

        // ADDI x5,x3,12 with x3=100 -> 112
        rf_hw[3]  = 32'd100;
        rf_ref[3] = 32'd100;
        do_instr(addi(5, 3, 12), 0, 1'b0);
        // x0 destination: no write, still retired
        do_instr(addi(0, 1, 7), 1, 1'b0);
        // ADD x1,x2,x3 is illegal
        do_instr(32'h003100B3, 0, 1'b0);
        // Response in the last allowed WAIT cycle, negative immediate
        do_instr(addi(6, 5, -1), TMO - 1, 1'b0);

        // Back-to-back with instr_valid held high
        do_instr(addi(7, 6, 3), 0, 1'b1);
        spacing_armed = 1'b1;
        do_instr(addi(8, 7, -2048), 0, 1'b1);
        do_instr(addi(9, 8, 2047), 0, 1'b0);
        spacing_armed = 1'b0;

        // Randomized mix of legal and illegal instructions
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
                if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) w[12] = 1'b1;
            end else begin
                w = addi($urandom_range(0, 31), $urandom_range(0, 31),
                         int'($urandom_range(0, 4095)));
            end
            do_instr(w, $urandom_range(0, TMO - 1), (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        // ALU never answers -> sticky ERROR until reset
        do_instr(addi(10, 4, 1), TMO, 1'b0);
        instr_valid = 1'b1;
        instr_data  = addi(11, 2, 5);
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", timeout_error, 1);
        check("err_ready",  instr_ready, 0);
        instr_valid = 1'b0;
        do_reset();
        do_instr(addi(12, 1, 33), 2, 1'b0);

        // Reset in the middle of WAIT aborts without a write
        instr_valid = 1'b1;
        instr_data  = addi(13, 2, 5);
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midwait_busy", busy, 1);
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        check("midwait_idle_ready", instr_ready, 1);
        check("write_count", 64'(wr_seen), 64'(wr_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
